// File: rtl/inst_rom_fetch.sv
// Instruction fetch front end: streams sequential words out of a synchronous ROM
// into a small prefetch FIFO, with single-cycle branch redirect and flush.
module inst_rom_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_FETCH} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  state_e                     state_q;
  logic [ADDR_WIDTH-1:0]      fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0]      resp_addr_q;
  logic                       inflight_q;
  entry_t [FIFO_DEPTH-1:0]    mem_q;
  logic [PW-1:0]              rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]              count_q, count_d;
  logic [CW:0]                used;
  logic                       credit_ok;
  logic                       push, pop;

  // Words already buffered plus the one still in the ROM pipe must leave room,
  // so a response can never arrive to a full FIFO.
  assign used      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = used < (CW+1)'(FIFO_DEPTH);

  assign rom_en_o      = (state_q == S_FETCH) && !branch_i && credit_ok;
  assign rom_addr_o    = fetch_addr_q;
  assign instr_valid_o = (count_q != '0) && !branch_i;
  assign instr_rdata_o = mem_q[rd_ptr_q].data;
  assign instr_addr_o  = mem_q[rd_ptr_q].addr;

  // A response landing in a branch cycle belongs to the old path and is dropped.
  assign push = inflight_q && !branch_i;
  assign pop  = instr_valid_o && instr_ready_i;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (branch_i)      fetch_addr_d = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
    else if (rom_en_o) fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(4);
  end

  always_comb begin
    count_d = count_q;
    if (branch_i)          count_d = '0;
    else if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= BOOT_ADDR;
      resp_addr_q  <= '0;
      inflight_q   <= 1'b0;
      mem_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= fetch_en_i ? S_FETCH : S_IDLE;
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= rom_en_o;
      count_q      <= count_d;
      if (rom_en_o) resp_addr_q <= fetch_addr_q;
      if (branch_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{data: rom_rdata_i, addr: resp_addr_q};
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_fetch.sv
// Randomized bench for inst_rom_fetch: issue-side scoreboard of expected words,
// monitor pops and compares on every consumer transfer.
module tb_inst_rom_fetch;
  localparam int              AW    = 10;
  localparam int              DW    = 32;
  localparam int              DEPTH = 4;
  localparam logic [AW-1:0]   BOOT  = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_en_i = 1'b0;
  logic          branch_i = 1'b0;
  logic [AW-1:0] branch_addr_i = '0;
  logic          rom_en_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_rdata_i = '0;
  logic          instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic [DW-1:0] instr_rdata_o;
  logic [AW-1:0] instr_addr_o;

  inst_rom_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
    .rom_rdata_i(rom_rdata_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_rdata_o(instr_rdata_o), .instr_addr_o(instr_addr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romf(input logic [AW-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // ROM: one-cycle read latency, garbage when not strobed
  always @(posedge clk) rom_rdata_i <= rom_en_o ? romf(rom_addr_o) : $urandom;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } sb_t;

  sb_t           sb[$];
  logic [AW-1:0] fetch_pc = BOOT;
  bit            fen_s = 1'b0;
  bit            exp_en, exp_vld;

  // Monitor: all outputs are stable mid-cycle; model advances as of the next edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_rom_en", 32'(rom_en_o), 32'd0);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr_o), 32'(BOOT));
      chk("rst_rdata", instr_rdata_o, 32'd0);
      chk("rst_iaddr", 32'(instr_addr_o), 32'd0);
      sb.delete();
      fetch_pc = BOOT;
      fen_s    = 1'b0;
    end else begin
      exp_en  = fen_s && !branch_i && (sb.size() < DEPTH);
      exp_vld = !branch_i && (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
      chk("rom_en", 32'(rom_en_o), 32'(exp_en));
      chk("instr_valid", 32'(instr_valid_o), 32'(exp_vld));
      if (exp_en && rom_en_o) chk("rom_addr", 32'(rom_addr_o), 32'(fetch_pc));
      if (exp_vld && instr_valid_o) begin
        chk("instr_addr", 32'(instr_addr_o), 32'(sb[0].addr));
        chk("instr_rdata", instr_rdata_o, romf(sb[0].addr));
      end
      if (branch_i) begin
        sb.delete();
        fetch_pc = {branch_addr_i[AW-1:2], 2'b00};
      end else begin
        if (exp_vld && instr_ready_i) void'(sb.pop_front());
        if (exp_en) begin
          sb.push_back('{addr: fetch_pc, cyc: cyc});
          fetch_pc = fetch_pc + AW'(4);
        end
      end
      fen_s = fetch_en_i;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_branch(input logic [AW-1:0] a);
    branch_i = 1'b1;
    branch_addr_i = a;
    step(1);
    branch_i = 1'b0;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    // boot stream, full throughput
    fetch_en_i = 1'b1;
    instr_ready_i = 1'b1;
    step(20);
    // backpressure fills the buffer, then drains
    instr_ready_i = 1'b0;
    step(10);
    instr_ready_i = 1'b1;
    step(10);
    // branch with buffer full and a word in flight
    instr_ready_i = 1'b0;
    step(8);
    do_branch(AW'(10'h103));
    instr_ready_i = 1'b1;
    step(10);
    // stop and restart
    fetch_en_i = 1'b0;
    step(8);
    fetch_en_i = 1'b1;
    step(6);
    // address wrap
    do_branch(AW'(10'h3F8));
    step(10);
    // redirect while idle
    fetch_en_i = 1'b0;
    step(4);
    do_branch(AW'(10'h201));
    step(3);
    fetch_en_i = 1'b1;
    step(8);
    // reset with buffered words
    instr_ready_i = 1'b0;
    step(5);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    instr_ready_i = 1'b1;
    step(10);
    // random traffic
    repeat (3000) begin
      fetch_en_i    = ($urandom % 8) != 0;
      instr_ready_i = ($urandom % 4) != 0;
      branch_i      = ($urandom % 20) == 0;
      branch_addr_i = AW'($urandom);
      rst           = ($urandom % 300) == 0;
      step(1);
    end
    rst = 1'b0;
    branch_i = 1'b0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_rom_fetch.md
INST_ROM_FETCH -- requirements
Module: inst_rom_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default ROM_ADDR_WIDTH (RISCV_MCU_CONFIG), byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, prefetch buffer entries (power of two, >=2).
REQ-004 SHALL have parameter BOOT_ADDR, default 0, first fetch byte address after reset.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port fetch_en_i  input  1  fetching permitted.
REQ-008 SHALL have port branch_i  input  1  single-cycle redirect request.
REQ-009 SHALL have port branch_addr_i  input  ADDR_WIDTH  redirect byte address.
REQ-010 SHALL have port rom_en_o  output  1  ROM read strobe.
REQ-011 SHALL have port rom_addr_o  output  ADDR_WIDTH  ROM byte address, bits[1:0]=0.
REQ-012 SHALL have port rom_rdata_i  input  DATA_WIDTH  ROM data, valid one cycle after rom_en_o.
REQ-013 SHALL have port instr_valid_o  output  1  buffered instruction available.
REQ-014 SHALL have port instr_ready_i  input  1  consumer accepts.
REQ-015 SHALL have port instr_rdata_o  output  DATA_WIDTH  instruction word.
REQ-016 SHALL have port instr_addr_o  output  ADDR_WIDTH  byte address of instr_rdata_o.

Function
REQ-017 SHALL implement FSM IDLE/FETCH: IDLE->FETCH when fetch_en_i=1 sampled; FETCH->IDLE when fetch_en_i=0 sampled.
REQ-018 SHALL assert rom_en_o only in FETCH, with branch_i=0, and credit = FIFO_DEPTH - count - inflight > 0 (inflight = rom_en_o registered).
REQ-019 SHALL drive rom_addr_o from fetch_addr register; fetch_addr += 4 per issued read, wrapping modulo 2^ADDR_WIDTH.
REQ-020 SHALL capture rom_rdata_i with its issue address in the cycle after rom_en_o, pushing into the FIFO at that cycle's end (not killed).
REQ-021 Latency: rom_en_o in cycle N -> instr_valid_o with that word in cycle N+2 (FIFO previously empty).
REQ-022 SHALL sustain one instruction per cycle when instr_ready_i held 1.
REQ-023 Transfer SHALL occur when instr_valid_o & instr_ready_i; FIFO pops in order; instr_rdata_o/instr_addr_o stable while valid & !ready.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; credit rule SHALL make overflow impossible.
REQ-025 On branch_i: rom_en_o=0 and instr_valid_o=0 that cycle, FIFO flushed, outstanding response marked killed (discarded next cycle), fetch_addr <= branch_addr_i with bits[1:0] cleared.
REQ-026 Branch SHALL be honoured in IDLE too (address update + flush, no fetch).
REQ-027 fetch_en_i dropping SHALL stop new issues only; in-flight response still pushed; buffered words still delivered.
REQ-028 Read address wrap SHALL be transparent: word at max aligned address followed by word at 0.

Reset
REQ-029 SHALL reset asynchronously on rst=1: state IDLE, fetch_addr=BOOT_ADDR, FIFO empty, inflight=0, kill=0.
REQ-030 During reset rom_en_o=0, instr_valid_o=0, rom_addr_o=BOOT_ADDR, instr_rdata_o=0, instr_addr_o=0.
REQ-031 Reset mid-operation SHALL discard buffered and in-flight words; first post-reset fetch SHALL be BOOT_ADDR.

Verification
REQ-032 Boot: rst released, fetch_en_i=1, ready=1 -> rom_addr_o 0x0,0x4,0x8,... one per cycle; instr_valid_o two cycles after first rom_en_o, instr_addr_o 0x0,0x4 in order.
REQ-033 Backpressure: ready=0 for 10 cycles -> at most FIFO_DEPTH=4 words buffered, rom_en_o then 0; ready=1 -> 0x0..0xC delivered, fetching resumes at 0x10, no loss/duplication.
REQ-034 Branch: branch_i to 0x103 while 3 words buffered and 1 in flight -> all discarded, next rom_addr_o=0x100, next delivered instr_addr_o=0x100.
REQ-035 Stop/start: fetch_en_i=0 after issue at 0x20 -> 0x20 still delivered, no 0x24 read until fetch_en_i=1 again.
REQ-036 Wrap: ADDR_WIDTH=8, branch to 0xF8 -> delivered addresses 0xF8,0xFC,0x00.
REQ-037 Reset mid-stream: rst pulsed with FIFO non-empty -> outputs at reset values immediately; restart fetches from BOOT_ADDR.
